risc_mem_responder: RTL and testbench

- Memory-side bus target for the RISC CPU. It answers the controller's rd/wr/data_e strobes with the addressed word.
- Holds a 2^AWIDTH x DWIDTH array.
- Inserts a programmable number of wait states and signals completion with a ready handshake.
- Owns bus turnaround: it drives read data only when selected, and captures CPU write data only when data_e is high.

---
 rtl/risc_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_risc_mem_responder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_mem_responder.sv
// Memory-side bus target: rd/wr/data_e handshake with WAIT_CYCLES wait states and a ready strobe.
// Define MEM_BACKDOOR_EN to add the ld_en/ld_addr/ld_data program-preload port.
module risc_mem_responder #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic              data_e,
  input  logic [DWIDTH-1:0] data_in,
`ifdef MEM_BACKDOOR_EN
  input  logic              ld_en,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_data,
`endif
  output logic [DWIDTH-1:0] data_out,
  output logic              data_oe,
  output logic              ready,
  output logic              coll_err
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_WAIT, WR_DONE} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic              ready_q, ready_d;
  logic              coll_err_q, coll_err_d;

  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  logic              bd_en;
  logic [AWIDTH-1:0] bd_addr;
  logic [DWIDTH-1:0] bd_data;

`ifdef MEM_BACKDOOR_EN
  assign bd_en   = ld_en;
  assign bd_addr = ld_addr;
  assign bd_data = ld_data;
`else
  assign bd_en   = 1'b0;
  assign bd_addr = '0;
  assign bd_data = '0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    ready_d    = ready_q;
    coll_err_d = coll_err_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = wdata_q;
    case (state_q)
      IDLE: begin
        // Preload has priority; a bus request waiting behind it is simply re-sampled later.
        if (bd_en) begin
          mem_we    = 1'b1;
          mem_waddr = bd_addr;
          mem_wdata = bd_data;
        end else if (rd && wr) begin
          coll_err_d = 1'b1;
        end else if (rd) begin
          addr_d = addr;
          cnt_d  = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            state_d    = RD_DATA;
            data_out_d = mem[addr];
            data_oe_d  = 1'b1;
            ready_d    = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end else if (wr && data_e) begin
          addr_d  = addr;
          wdata_d = data_in;
          cnt_d   = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            state_d   = WR_DONE;
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = data_in;
            ready_d   = 1'b1;
          end else begin
            state_d = WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!rd) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d    = RD_DATA;
          data_out_d = mem[addr_q];
          data_oe_d  = 1'b1;
          ready_d    = 1'b1;
        end
      end
      RD_DATA: begin
        if (!rd) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
          ready_d   = 1'b0;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!wr) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = WR_DONE;
          mem_we  = 1'b1;
          ready_d = 1'b1;
        end
      end
      WR_DONE: begin
        if (!wr) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      ready_q    <= 1'b0;
      coll_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      ready_q    <= ready_d;
      coll_err_q <= coll_err_d;
    end
  end

  // The array is never reset; the rst_n gate keeps a held request from committing during reset.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign ready    = ready_q;
  assign coll_err = coll_err_q;

endmodule

// File: tb/tb_risc_mem_responder.sv
// Self-checking bench for risc_mem_responder: four instances with WAIT_CYCLES 0..3, scoreboard for read data.
// Define MEM_BACKDOOR_EN to also exercise the preload port.
module tb_risc_mem_responder;

  localparam int NINST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NINST-1:0]      rst_n_s, rd_s, wr_s, data_e_s;
  logic [NINST-1:0]      data_oe_s, ready_s, coll_err_s;
  logic [NINST-1:0][4:0] addr_s;
  logic [NINST-1:0][7:0] data_in_s, data_out_s;
`ifdef MEM_BACKDOOR_EN
  logic       ld_en;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] model [NINST][32];
  logic [7:0] exp_q [$];

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    risc_mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_CYCLES(g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n_s[g]),
      .addr     (addr_s[g]),
      .rd       (rd_s[g]),
      .wr       (wr_s[g]),
      .data_e   (data_e_s[g]),
      .data_in  (data_in_s[g]),
`ifdef MEM_BACKDOOR_EN
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
`endif
      .data_out (data_out_s[g]),
      .data_oe  (data_oe_s[g]),
      .ready    (ready_s[g]),
      .coll_err (coll_err_s[g])
    );
  end

  task automatic do_read(input int k, input logic [4:0] a);
    int n;
    logic [7:0] exp_v;
    exp_q.push_back(model[k][a]);
    @(negedge clk);
    addr_s[k] = a;
    rd_s[k]   = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (ready_s[k] === 1'b1) break;
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (n !== k + 1) begin
      failures++;
      $display("FAIL rd_latency inst%0d addr=%h: got %0d edges want %0d", k, a, n, k + 1);
    end
    checks++;
    if (data_oe_s[k] !== 1'b1) begin
      failures++;
      $display("FAIL rd_oe inst%0d addr=%h: got %b want 1", k, a, data_oe_s[k]);
    end
    checks++;
    if (data_out_s[k] !== exp_v) begin
      failures++;
      $display("FAIL rd_data inst%0d addr=%h: got %h want %h", k, a, data_out_s[k], exp_v);
    end
    @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (ready_s[k] !== 1'b1 || data_oe_s[k] !== 1'b1) begin
      failures++;
      $display("FAIL rd_hold inst%0d: got ready=%b oe=%b want 1 1", k, ready_s[k], data_oe_s[k]);
    end
    @(negedge clk);
    rd_s[k] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_s[k] !== 1'b0 || data_oe_s[k] !== 1'b0 || data_out_s[k] !== exp_v) begin
      failures++;
      $display("FAIL rd_release inst%0d: got ready=%b oe=%b data=%h want 0 0 %h",
               k, ready_s[k], data_oe_s[k], data_out_s[k], exp_v);
    end
  endtask

  task automatic do_write(input int k, input logic [4:0] a, input logic [7:0] d);
    int n;
    logic oe_seen;
    @(negedge clk);
    addr_s[k]    = a;
    data_in_s[k] = d;
    wr_s[k]      = 1'b1;
    data_e_s[k]  = 1'b1;
    n = 0;
    oe_seen = 1'b0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      oe_seen = oe_seen | data_oe_s[k];
      // Write data must have been captured on the request edge.
      if (n == 1) data_in_s[k] = ~d;
      if (ready_s[k] === 1'b1) break;
    end
    checks++;
    if (n !== k + 1) begin
      failures++;
      $display("FAIL wr_latency inst%0d addr=%h: got %0d edges want %0d", k, a, n, k + 1);
    end
    model[k][a] = d;
    @(negedge clk);
    wr_s[k]     = 1'b0;
    data_e_s[k] = 1'b0;
    @(posedge clk); #1;
    oe_seen = oe_seen | data_oe_s[k];
    checks++;
    if (ready_s[k] !== 1'b0 || oe_seen !== 1'b0) begin
      failures++;
      $display("FAIL wr_release inst%0d: got ready=%b oe_seen=%b want 0 0", k, ready_s[k], oe_seen);
    end
  endtask

  task automatic test_reset();
    rst_n_s = '0; rd_s = '0; wr_s = '0; data_e_s = '0; addr_s = '0; data_in_s = '0;
`ifdef MEM_BACKDOOR_EN
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
`endif
    #22;
    for (int k = 0; k < NINST; k++) begin
      checks++;
      if (data_out_s[k] !== 8'h00 || data_oe_s[k] !== 1'b0 || ready_s[k] !== 1'b0 ||
          coll_err_s[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset inst%0d: got data=%h oe=%b ready=%b coll=%b want 00 0 0 0",
                 k, data_out_s[k], data_oe_s[k], ready_s[k], coll_err_s[k]);
      end
    end
    @(negedge clk);
    rst_n_s = '1;
  endtask

  task automatic test_write_read();
    do_write(1, 5'h0A, 8'h3C);
    do_read(1, 5'h0A);
  endtask

  task automatic test_zero_wait();
    do_write(0, 5'h1F, 8'hA5);
    do_read(0, 5'h1F);
  endtask

  task automatic test_write_gating();
    int n;
    logic early;
    @(negedge clk);
    addr_s[1] = 5'h0B; data_in_s[1] = 8'h6D; wr_s[1] = 1'b1; data_e_s[1] = 1'b0;
    early = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      early = early | ready_s[1];
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL wr_no_data_e: got ready=1 want 0");
    end
    @(negedge clk);
    data_e_s[1] = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (ready_s[1] === 1'b1) break;
    end
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL wr_gated_latency: got %0d edges want 2", n);
    end
    model[1][5'h0B] = 8'h6D;
    @(negedge clk);
    wr_s[1] = 1'b0; data_e_s[1] = 1'b0;
    do_read(1, 5'h0B);
  endtask

  task automatic test_read_abort();
    logic seen;
    do_write(3, 5'h05, 8'h5A);
    @(negedge clk);
    addr_s[3] = 5'h05; rd_s[3] = 1'b1;
    @(negedge clk);
    rd_s[3] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | ready_s[3] | data_oe_s[3];
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rd_abort: got ready/oe activity=1 want 0");
    end
    do_read(3, 5'h05);
  endtask

  task automatic test_collision();
    do_write(1, 5'h07, 8'h42);
    @(negedge clk);
    addr_s[1] = 5'h07; data_in_s[1] = 8'h99;
    rd_s[1] = 1'b1; wr_s[1] = 1'b1; data_e_s[1] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (coll_err_s[1] !== 1'b1 || ready_s[1] !== 1'b0) begin
      failures++;
      $display("FAIL coll_set: got coll=%b ready=%b want 1 0", coll_err_s[1], ready_s[1]);
    end
    @(negedge clk);
    rd_s[1] = 1'b0; wr_s[1] = 1'b0; data_e_s[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (coll_err_s[1] !== 1'b1) begin
      failures++;
      $display("FAIL coll_sticky: got %b want 1", coll_err_s[1]);
    end
    checks++;
    if (coll_err_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL coll_isolated inst0: got %b want 0", coll_err_s[0]);
    end
    do_read(1, 5'h07);
  endtask

  task automatic test_reset_mid_write();
    do_write(2, 5'h03, 8'h21);
    do_read(2, 5'h03);
    @(negedge clk);
    addr_s[2] = 5'h03; data_in_s[2] = 8'h77; wr_s[2] = 1'b1; data_e_s[2] = 1'b1;
    @(posedge clk); #1;
    rst_n_s[2] = 1'b0;
    #1;
    checks++;
    if (data_out_s[2] !== 8'h00 || data_oe_s[2] !== 1'b0 || ready_s[2] !== 1'b0 ||
        coll_err_s[2] !== 1'b0) begin
      failures++;
      $display("FAIL async_reset inst2: got data=%h oe=%b ready=%b coll=%b want 00 0 0 0",
               data_out_s[2], data_oe_s[2], ready_s[2], coll_err_s[2]);
    end
    wr_s[2] = 1'b0; data_e_s[2] = 1'b0;
    @(negedge clk);
    rst_n_s[2] = 1'b1;
    do_read(2, 5'h03);
  endtask

  task automatic test_back_to_back();
    logic [4:0] a;
    for (int k = 0; k < NINST; k++) begin
      for (int i = 0; i < 3; i++) begin
        a = 5'(i * 7 + k * 3 + 20);
        do_write(k, a, 8'($urandom_range(0, 255)));
      end
      for (int i = 0; i < 3; i++) begin
        a = 5'(i * 7 + k * 3 + 20);
        do_read(k, a);
      end
    end
  endtask

`ifdef MEM_BACKDOOR_EN
  task automatic test_backdoor();
    int n;
    logic [7:0] exp_v;
    logic early;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 5'(i); ld_data = 8'(8'h11 + i);
      for (int k = 0; k < NINST; k++) model[k][i] = 8'(8'h11 + i);
    end
    @(negedge clk);
    ld_en = 1'b0;
    for (int i = 0; i < 4; i++) do_read(1, 5'(i));
    exp_q.push_back(model[1][0]);
    @(negedge clk);
    addr_s[1] = 5'h00; rd_s[1] = 1'b1;
    ld_en = 1'b1; ld_addr = 5'h04; ld_data = 8'h55;
    for (int k = 0; k < NINST; k++) model[k][4] = 8'h55;
    early = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      early = early | ready_s[1];
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL bd_block: got ready=1 during ld_en want 0");
    end
    @(negedge clk);
    ld_en = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (ready_s[1] === 1'b1) break;
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (n !== 2 || data_out_s[1] !== exp_v) begin
      failures++;
      $display("FAIL bd_deferred_rd: got %0d edges data=%h want 2 %h", n, data_out_s[1], exp_v);
    end
    @(negedge clk);
    rd_s[1] = 1'b0;
    @(posedge clk);
    do_read(1, 5'h04);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_write_gating();
    test_read_abort();
    test_collision();
    test_reset_mid_write();
    test_back_to_back();
`ifdef MEM_BACKDOOR_EN
    test_backdoor();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
